// File: rtl/cu_wf_slot_tracker_pkg.sv
// Shared widths for the CU wavefront slot tracker.
// The tag is {wg_slot_id, wf_idx}; the slot count sets the warp-id width.
package cu_wf_slot_tracker_pkg;
    localparam int WG_SLOT_ID_WIDTH      = 5;
    localparam int WF_COUNT_WIDTH_PER_WG = 3;
    localparam int TAG_WIDTH             = WG_SLOT_ID_WIDTH + WF_COUNT_WIDTH_PER_WG;
    localparam int NUMBER_WARP           = 8;
    localparam int WARP_ID_WIDTH         = 3;

    typedef logic [TAG_WIDTH-1:0] wf_tag_t;
endpackage

// File: rtl/cu_wf_slot_tracker_pick.sv
// Lowest-index picker: fixed-priority grant followed by one-hot to binary.
// Outputs {found, index}; index is 0 when nothing is requested.
module cu_wf_slot_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] index
);
    logic [N-1:0] grant;

    always_comb begin
        logic taken;
        taken = 1'b0;
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !taken) begin
                grant[i] = 1'b1;
                taken    = 1'b1;
            end
        end
    end

    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) index = index | W'(i);
        end
    end

    assign found = |req;
endmodule

// File: rtl/cu_wf_slot_tracker.sv
// CU-side wavefront slot tracker: binds dispatches to warp slots, starts them, returns done tags.
// Optional tag/protocol checking is built only when CU_WF_TAG_CHECK_EN is defined.
import cu_wf_slot_tracker_pkg::*;

module cu_wf_slot_tracker #(
    parameter int NUM_WARP  = NUMBER_WARP,
    parameter int WID_WIDTH = WARP_ID_WIDTH,
    parameter int TAG_W     = TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dispatch2cu_wf_dispatch_i,
    input  logic [TAG_W-1:0]     dispatch2cu_wf_tag_dispatch_i,
    output logic                 ready_for_dispatch2cu_o,
    output logic                 warp_start_valid_o,
    input  logic                 warp_start_ready_i,
    output logic [WID_WIDTH-1:0] warp_start_wid_o,
    output logic [TAG_W-1:0]     warp_start_tag_o,
    input  logic                 warp_end_valid_i,
    input  logic [WID_WIDTH-1:0] warp_end_wid_i,
    output logic                 cu2dispatch_wf_done_o,
    output logic [TAG_W-1:0]     cu2dispatch_wf_tag_done_o,
    output logic [NUM_WARP-1:0]  busy_mask_o,
    output logic                 tag_err_o
);
    localparam int CW = WID_WIDTH + 1;

    logic [NUM_WARP-1:0]  busy, pend, busy_next, pend_next;
    logic [TAG_W-1:0]     tags [NUM_WARP];
    logic                 free_found, start_found;
    logic [WID_WIDTH-1:0] free_idx, start_idx;
    logic                 alloc_fire, start_fire, end_fire;
    logic [CW-1:0]        busy_cnt, free_cnt, free_next;
    logic                 ready_q, ready_next, done_q;
    logic [TAG_W-1:0]     tag_done_q;

    cu_wf_slot_pick #(.N(NUM_WARP), .W(WID_WIDTH)) u_free_pick (
        .req   (~busy),
        .found (free_found),
        .index (free_idx)
    );

    cu_wf_slot_pick #(.N(NUM_WARP), .W(WID_WIDTH)) u_start_pick (
        .req   (pend),
        .found (start_found),
        .index (start_idx)
    );

    assign alloc_fire = dispatch2cu_wf_dispatch_i && free_found;
    assign start_fire = start_found && warp_start_ready_i;
    assign end_fire   = warp_end_valid_i && busy[warp_end_wid_i] && !pend[warp_end_wid_i];

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_WARP; i++) begin
            busy_cnt = busy_cnt + CW'(busy[i]);
        end
        free_cnt = CW'(NUM_WARP) - busy_cnt;
    end

    // The extra credit at free==1 only goes out if the previous cycle withheld it,
    // so one in-flight dispatch after ready falls can never find the slots full.
    assign free_next  = free_cnt - CW'(alloc_fire) + CW'(end_fire);
    assign ready_next = (free_next >= CW'(2)) || ((free_next == CW'(1)) && !ready_q);

    // Allocation uses the pre-edge busy mask, so a slot ending now is never reused this cycle.
    always_comb begin
        busy_next = busy;
        pend_next = pend;
        if (start_fire) pend_next[start_idx] = 1'b0;
        if (end_fire)   busy_next[warp_end_wid_i] = 1'b0;
        if (alloc_fire) begin
            busy_next[free_idx] = 1'b1;
            pend_next[free_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            pend       <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            tag_done_q <= '0;
            for (int i = 0; i < NUM_WARP; i++) tags[i] <= '0;
        end else begin
            busy    <= busy_next;
            pend    <= pend_next;
            ready_q <= ready_next;
            done_q  <= end_fire;
            if (alloc_fire) tags[free_idx] <= dispatch2cu_wf_tag_dispatch_i;
            if (end_fire)   tag_done_q <= tags[warp_end_wid_i];
        end
    end

`ifdef CU_WF_TAG_CHECK_EN
    logic err_q, dup_hit, err_set;

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < NUM_WARP; i++) begin
            if (busy[i] && (tags[i] == dispatch2cu_wf_tag_dispatch_i)) dup_hit = 1'b1;
        end
    end

    assign err_set = (dispatch2cu_wf_dispatch_i && (!free_found || dup_hit))
                   || (warp_end_valid_i && !end_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign tag_err_o = err_q;
`else
    assign tag_err_o = 1'b0;
`endif

    assign ready_for_dispatch2cu_o   = ready_q;
    assign warp_start_valid_o        = start_found;
    assign warp_start_wid_o          = start_idx;
    assign warp_start_tag_o          = tags[start_idx];
    assign cu2dispatch_wf_done_o     = done_q;
    assign cu2dispatch_wf_tag_done_o = tag_done_q;
    assign busy_mask_o               = busy;
endmodule
